// File: rtl/npu_window_pkg.sv
// Shared types and helpers for the K x K sliding-window generator.
// Tap addressing, counter sizing and the fill/stream decode.
package npu_window_pkg;

  typedef enum logic {
    FILL,
    STREAM
  } win_state_e;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int tap_lsb(
    input int r,
    input int c,
    input int k,
    input int bd
  );
    return (r * k + c) * bd;
  endfunction

endpackage

// File: rtl/window_row_shift.sv
// One window row: K-tap shift register, newest pixel at tap 0.
// Taps advance only when enabled.
module window_row_shift #(
  parameter int BIT_DEPTH = 8,
  parameter int K         = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [BIT_DEPTH-1:0]   din,
  output logic [K*BIT_DEPTH-1:0] taps
);

  // shift the row by one tap on enable
  always_ff @(posedge clk) begin
    if (rst) begin
      taps <= '0;
    end else if (en) begin
      taps <= {taps[(K-1)*BIT_DEPTH-1:0], din};
    end
  end

endmodule

// File: rtl/window_kxk_stream.sv
// K x K sliding-window generator with valid/ready handshakes.
// Tracks the row column index and flags windows that lie in one row.
module window_kxk_stream
  import npu_window_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int K         = 3,
  parameter int IMG_WIDTH = 640
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [K*BIT_DEPTH-1:0]        in_col,
  input  logic                          in_sol,
  output logic                          win_valid,
  input  logic                          win_ready,
  output logic [K*K*BIT_DEPTH-1:0]      win_data,
  output logic [cnt_w(IMG_WIDTH)-1:0]   win_col,
  output logic                          win_last
);

  localparam int CNT_W = cnt_w(IMG_WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_IDX = CNT_W'(K - 1);

  logic [CNT_W-1:0] col_cnt;
  logic [CNT_W-1:0] idx;
  logic             accept;
  logic             last_idx;
  win_state_e       state;

  assign in_ready = ~rst & (~win_valid | win_ready);
  assign accept   = in_valid & in_ready;

  // index of the incoming column and whether it completes a window
  always_comb begin
    idx      = in_sol ? '0 : col_cnt;
    last_idx = (idx == LAST_IDX);
    state    = FILL;
    if (idx >= FULL_IDX) begin
      state = STREAM;
    end
  end

  // row counter, window flags and window column tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt   <= '0;
      win_col   <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (accept) begin
      col_cnt   <= last_idx ? '0 : idx + CNT_W'(1);
      win_col   <= idx;
      win_valid <= (state == STREAM);
      win_last  <= last_idx;
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    window_row_shift #(
      .BIT_DEPTH(BIT_DEPTH),
      .K        (K)
    ) u_row (
      .clk (clk),
      .rst (rst),
      .en  (accept),
      .din (in_col[r*BIT_DEPTH +: BIT_DEPTH]),
      .taps(win_data[tap_lsb(r, 0, K, BIT_DEPTH) +: K*BIT_DEPTH])
    );
  end

endmodule

// File: tb/tb_window_kxk_stream.sv
// Directed and randomized checks of the K x K window generator
// against a column-history reference model.
module tb_window_kxk_stream;

  localparam int BD = 8;
  localparam int K  = 3;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [23:0]   in_col;
  logic          in_sol;
  logic          win_valid;
  logic          win_ready;
  logic [71:0]   win_data;
  logic [2:0]    win_col;
  logic          win_last;

  int tests = 0;
  int fails = 0;
  int dut_new = 0;
  int dut_last = 0;
  int dut_cons = 0;

  logic        m_valid = 1'b0;
  logic [71:0] m_data = '0;
  int          m_col = 0;
  logic        m_last = 1'b0;
  int          m_cnt = 0;
  logic [23:0] hist[$];

  logic [23:0] img[4][W];

  always #5 clk = ~clk;

  window_kxk_stream #(
    .BIT_DEPTH(BD),
    .K        (K),
    .IMG_WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_col   (in_col),
    .in_sol   (in_sol),
    .win_valid(win_valid),
    .win_ready(win_ready),
    .win_data (win_data),
    .win_col  (win_col),
    .win_last (win_last)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] colv(input int j);
    logic [23:0] v;
    for (int r = 0; r < K; r++) v[r*8 +: 8] = 8'(16 * r + j);
    return v;
  endfunction

  function automatic logic [71:0] build();
    logic [71:0] d;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        d[(r*K+c)*8 +: 8] = hist[hist.size()-1-c][r*8 +: 8];
    return d;
  endfunction

  task automatic cyc(input logic v, input logic [23:0] c, input logic s,
                     input logic rd, output logic acc);
    int idx;
    in_valid  = v;
    in_col    = c;
    in_sol    = s;
    win_ready = rd;
    #1;
    chk("in_ready", 72'(in_ready), 72'(!m_valid || rd));
    acc = v && (!m_valid || rd);
    if (win_valid && rd) dut_cons++;
    @(posedge clk);
    if (acc) begin
      idx = s ? 0 : m_cnt;
      if (idx == 0) hist.delete();
      hist.push_back(c);
      m_cnt   = (idx == W - 1) ? 0 : idx + 1;
      m_col   = idx;
      m_last  = (idx == W - 1);
      m_valid = (hist.size() >= K);
      if (m_valid) m_data = build();
    end else if (rd) begin
      m_valid = 1'b0;
    end
    #1;
    chk("win_valid", 72'(win_valid), 72'(m_valid));
    chk("win_col", 72'(win_col), 72'(m_col));
    chk("win_last", 72'(win_last), 72'(m_last));
    if (m_valid) chk("win_data", win_data, m_data);
    if (acc && win_valid) dut_new++;
    if (acc && win_valid && win_last) dut_last++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_sol    = 1'b0;
    win_ready = 1'b0;
    #1;
    chk("rst_in_ready", 72'(in_ready), 72'(0));
    @(posedge clk);
    m_valid = 1'b0;
    m_data  = '0;
    m_col   = 0;
    m_last  = 1'b0;
    m_cnt   = 0;
    hist.delete();
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_valid", 72'(win_valid), 72'(0));
    chk("rst_data", win_data, 72'(0));
    chk("rst_col", 72'(win_col), 72'(0));
    chk("rst_last", 72'(win_last), 72'(0));
    chk("post_rst_ready", 72'(in_ready), 72'(1));
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic        a;
    logic [71:0] held;
    int          row;
    int          pos;
    int          n;

    rst = 1'b1;
    in_valid = 1'b0;
    in_col = '0;
    in_sol = 1'b0;
    win_ready = 1'b0;
    @(negedge clk);
    do_reset();

    dut_new = 0;
    dut_last = 0;
    for (int j = 0; j < W; j++) begin
      cyc(1'b1, colv(j), j == 0, 1'b1, a);
      if (j == 2) begin
        chk("tap00", 72'(win_data[7:0]), 72'(8'h02));
        chk("tap01", 72'(win_data[15:8]), 72'(8'h01));
        chk("tap02", 72'(win_data[23:16]), 72'(8'h00));
        chk("tap20", 72'(win_data[55:48]), 72'(8'h22));
      end
    end
    chk("row1_windows", 72'(dut_new), 72'(6));
    chk("row1_lasts", 72'(dut_last), 72'(1));

    dut_new = 0;
    for (int j = 0; j < 2 * W; j++) begin
      cyc(1'b1, colv(j % W), 1'b0, 1'b1, a);
      if (j == W + 1) chk("row2_fill", 72'(win_valid), 72'(0));
      if (j == W + 2) chk("row2_first_col", 72'(win_col), 72'(2));
    end
    chk("two_row_windows", 72'(dut_new), 72'(12));

    for (int j = 0; j < 3; j++) cyc(1'b1, colv(j), 1'b0, 1'b1, a);
    held = win_data;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, colv(3), 1'b0, 1'b0, a);
      chk("stall_acc", 72'(a), 72'(0));
      chk("stall_data", win_data, held);
    end
    cyc(1'b1, colv(3), 1'b0, 1'b1, a);
    chk("release_acc", 72'(a), 72'(1));
    for (int j = 4; j < W; j++) cyc(1'b1, colv(j), 1'b0, 1'b1, a);

    for (int j = 0; j < 4; j++) cyc(1'b1, colv(j), 1'b0, 1'b1, a);
    cyc(1'b1, colv(4), 1'b1, 1'b1, a);
    chk("sol_col0", 72'(win_valid), 72'(0));
    cyc(1'b1, colv(5), 1'b0, 1'b1, a);
    chk("sol_col1", 72'(win_valid), 72'(0));
    cyc(1'b1, colv(6), 1'b0, 1'b1, a);
    chk("sol_win", 72'(win_valid), 72'(1));
    chk("sol_win_col", 72'(win_col), 72'(2));
    for (int j = 3; j < W; j++) cyc(1'b1, colv(j), 1'b0, 1'b1, a);

    for (int j = 0; j < 5; j++) cyc(1'b1, colv(j), 1'b0, 1'b1, a);
    chk("pre_rst_valid", 72'(win_valid), 72'(1));
    do_reset();
    for (int j = 0; j < 3; j++) cyc(1'b1, colv(j), 1'b0, 1'b1, a);
    chk("post_rst_win", 72'(win_valid), 72'(1));
    chk("post_rst_col", 72'(win_col), 72'(2));

    for (int r = 0; r < 4; r++)
      for (int j = 0; j < W; j++)
        img[r][j] = 24'($urandom);
    cyc(1'b0, 24'h0, 1'b0, 1'b1, a);
    dut_new = 0;
    dut_cons = 0;
    row = 0;
    pos = 0;
    n = 0;
    while (row < 4 && n < 2000) begin
      cyc(($urandom_range(0, 3) != 0), img[row][pos], pos == 0,
          ($urandom_range(0, 2) != 0), a);
      n++;
      if (a) begin
        pos++;
        if (pos == W) begin
          pos = 0;
          row++;
        end
      end
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 24'h0, 1'b0, 1'b1, a);
    chk("rand_rows_done", 72'(row), 72'(4));
    chk("rand_windows", 72'(dut_new), 72'(24));
    chk("rand_consumed", 72'(dut_cons), 72'(24));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
